// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU data port, DMA/loader port and one-port data-memory pins around dmem_arbiter.
// master = requesters plus memory model; slave = the arbiter that owns the mem_* pins.
interface dmem_arbiter_if #(
  parameter int AW = 14
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_lock;
  logic          dma_gnt;
  logic [31:0]   dma_rdata;
  logic          dma_rvalid;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the one-port data memory; CPU has priority, DMA may lock bursts; DMEM_ARB_STARVE_GUARD_EN adds a DMA starvation guard.
// Latency: CPU 0 cycles, DMA grant in-cycle with read data 1 cycle later; losers see cpu_stall / no dma_gnt and hold their request.
module dmem_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int AW       = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  // Clamp keeps out-of-range settings from producing a never-firing or always-firing guard.
  localparam logic [7:0] WAIT_LIMIT = (MAX_WAIT < 1)   ? 8'd1   :
                                      (MAX_WAIT > 255) ? 8'd255 : 8'(MAX_WAIT);

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_d;
  logic          starve;
  logic          cpu_gnt;
  logic          dma_gnt;
  logic          dma_rd;
  logic [31:0]   dma_rdata_q;
  logic          dma_rvalid_q;
  logic          mux_we;
  logic [AW-1:0] mux_addr;
  logic [31:0]   mux_wdata;

  // Constant-folds to 0 in the default build, leaving CPU with strict priority.
  assign starve = GUARD_EN && bus.dma_req && (wait_cnt >= WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    state_d = state_q;
    wait_d  = 8'd0;

    if (rst_n) begin
      if ((state_q == ARB_LOCKED) && bus.dma_req) begin
        dma_gnt = 1'b1;
      end else if (starve) begin
        dma_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end

    if (dma_gnt && bus.dma_lock) begin
      state_d = ARB_LOCKED;
    end else if (!bus.dma_lock || !bus.dma_req) begin
      state_d = ARB_OPEN;
    end

    if (bus.dma_req && !dma_gnt) begin
      wait_d = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end
  end

  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = 32'd0;
    if (cpu_gnt) begin
      mux_we    = bus.cpu_we;
      mux_addr  = bus.cpu_addr;
      mux_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      mux_we    = bus.dma_we;
      mux_addr  = bus.dma_addr;
      mux_wdata = bus.dma_wdata;
    end
  end

  assign dma_rd = dma_gnt & ~bus.dma_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt     <= 8'd0;
      dma_rdata_q  <= 32'd0;
      dma_rvalid_q <= 1'b0;
    end else begin
      wait_cnt     <= wait_d;
      dma_rvalid_q <= dma_rd;
      if (dma_rd) begin
        dma_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_we     = mux_we;
  assign bus.mem_addr   = mux_addr;
  assign bus.mem_wdata  = mux_wdata;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = rst_n & bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-port memory; expectations follow the guard macro.
module tb_dmem_arbiter;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  dmem_arbiter_if #(.AW(AW)) bus ();

  dmem_arbiter #(.MAX_WAIT(8), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 32'd0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = 32'd0;
    bus.dma_lock = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0001; bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 14'h0002;
    step(); #1;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); else passes++;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL rst_cpu_stall: got %b want 0", bus.cpu_stall); else passes++;
    checks++; if (bus.dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt: got %b want 0", bus.dma_gnt); else passes++;
    step();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL rst_dma_rvalid: got %b want 0", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_rdata !== 32'd0) $display("FAIL rst_dma_rdata: got %h want 0", bus.dma_rdata); else passes++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL idle_mem_we: got %b want 0", bus.mem_we); else passes++;
    checks++; if (bus.mem_addr !== 14'd0) $display("FAIL idle_mem_addr: got %h want 0", bus.mem_addr); else passes++;
    checks++; if (bus.mem_wdata !== 32'd0) $display("FAIL idle_mem_wdata: got %h want 0", bus.mem_wdata); else passes++;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL idle_cpu_stall: got %b want 0", bus.cpu_stall); else passes++;
    checks++; if (bus.dma_gnt !== 1'b0) $display("FAIL idle_dma_gnt: got %b want 0", bus.dma_gnt); else passes++;
  endtask

  task automatic test_cpu_only();
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0010; bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL cpu_st_we: got %b want 1", bus.mem_we); else passes++;
    checks++; if (bus.mem_addr !== 14'h0010) $display("FAIL cpu_st_addr: got %h want 0010", bus.mem_addr); else passes++;
    checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL cpu_st_wdata: got %h want deadbeef", bus.mem_wdata); else passes++;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL cpu_st_stall: got %b want 0", bus.cpu_stall); else passes++;
    step();
    bus.cpu_we = 1'b0; bus.cpu_wdata = 32'd0;
    #1;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL cpu_ld_we: got %b want 0", bus.mem_we); else passes++;
    checks++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL cpu_ld_rdata: got %h want deadbeef", bus.cpu_rdata); else passes++;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL cpu_ld_stall: got %b want 0", bus.cpu_stall); else passes++;
    step();
    idle_inputs();
  endtask

  task automatic test_dma_read();
    step();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 14'h0010;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1) $display("FAIL dma_rd_gnt: got %b want 1", bus.dma_gnt); else passes++;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL dma_rd_early_rvalid: got %b want 0", bus.dma_rvalid); else passes++;
    step();
    idle_inputs();
    #1;
    checks++; if (bus.dma_rvalid !== 1'b1) $display("FAIL dma_rd_rvalid: got %b want 1", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_rdata !== 32'hDEAD_BEEF) $display("FAIL dma_rd_rdata: got %h want deadbeef", bus.dma_rdata); else passes++;
    step(); #1;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL dma_rd_pulse: got %b want 0", bus.dma_rvalid); else passes++;
  endtask

  task automatic test_back_to_back();
    step();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 14'h0020; bus.dma_wdata = 32'h1234_5678;
    #1;
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL b2b_wr_we: got %b want 1", bus.mem_we); else passes++;
    step();
    bus.dma_we = 1'b0; bus.dma_wdata = 32'd0;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL b2b_wr_rvalid: got %b want 0", bus.dma_rvalid); else passes++;
    step();
    bus.dma_addr = 14'h0010;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b1) $display("FAIL b2b_rv1: got %b want 1", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_rdata !== 32'h1234_5678) $display("FAIL b2b_raw_data: got %h want 12345678", bus.dma_rdata); else passes++;
    step();
    idle_inputs();
    #1;
    checks++; if (bus.dma_rvalid !== 1'b1) $display("FAIL b2b_rv2: got %b want 1", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_rd2_data: got %h want deadbeef", bus.dma_rdata); else passes++;
    step(); #1;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL b2b_rv_end: got %b want 0", bus.dma_rvalid); else passes++;
  endtask

  task automatic test_contention();
    logic exp_gnt;
    step();
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0010;
    bus.dma_req = 1'b1; bus.dma_addr = 14'h0020;
    for (int k = 1; k <= 27; k++) begin
      if (k > 1) step();
      #1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      exp_gnt = (k % 9 == 0);
`else
      exp_gnt = 1'b0;
`endif
      checks++; if (bus.dma_gnt !== exp_gnt) $display("FAIL cont_dma_gnt[%0d]: got %b want %b", k, bus.dma_gnt, exp_gnt); else passes++;
      checks++; if (bus.cpu_stall !== exp_gnt) $display("FAIL cont_cpu_stall[%0d]: got %b want %b", k, bus.cpu_stall, exp_gnt); else passes++;
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_burst_lock();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b1;
    bus.dma_addr = 14'h0030; bus.dma_wdata = 32'h0000_00A0;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1) $display("FAIL burst_beat0_gnt: got %b want 1", bus.dma_gnt); else passes++;
    for (int b = 1; b < 4; b++) begin
      step();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0010;
      bus.dma_addr = 14'h0030 + 14'(b); bus.dma_wdata = 32'h0000_00A0 + 32'(b);
      #1;
      checks++; if (bus.dma_gnt !== 1'b1) $display("FAIL burst_gnt[%0d]: got %b want 1", b, bus.dma_gnt); else passes++;
      checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL burst_stall[%0d]: got %b want 1", b, bus.cpu_stall); else passes++;
      checks++; if (bus.mem_addr !== 14'h0030 + 14'(b)) $display("FAIL burst_addr[%0d]: got %h want %h", b, bus.mem_addr, 14'h0030 + 14'(b)); else passes++;
    end
    step();
    bus.dma_req = 1'b0; bus.dma_lock = 1'b0; bus.dma_we = 1'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL burst_cpu_after: got %b want 0", bus.cpu_stall); else passes++;
    checks++; if (bus.mem_addr !== 14'h0010) $display("FAIL burst_cpu_addr: got %h want 0010", bus.mem_addr); else passes++;
    checks++; if (mem[14'h0033] !== 32'h0000_00A3) $display("FAIL burst_mem_beat3: got %h want 000000a3", mem[14'h0033]); else passes++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_burst();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b1; bus.dma_addr = 14'h0010;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1) $display("FAIL rmb_gnt: got %b want 1", bus.dma_gnt); else passes++;
    step();
    rst_n = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0020;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0) $display("FAIL rmb_rst_gnt: got %b want 0", bus.dma_gnt); else passes++;
    checks++; if (bus.dma_rvalid !== 1'b1) $display("FAIL rmb_prev_rvalid: got %b want 1", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_rdata !== 32'hDEAD_BEEF) $display("FAIL rmb_prev_rdata: got %h want deadbeef", bus.dma_rdata); else passes++;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) $display("FAIL rmb_rvalid: got %b want 0", bus.dma_rvalid); else passes++;
    checks++; if (bus.dma_gnt !== 1'b0) $display("FAIL rmb_lock_cleared: got %b want 0", bus.dma_gnt); else passes++;
    checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL rmb_cpu_wins: got %b want 0", bus.cpu_stall); else passes++;
    checks++; if (bus.mem_addr !== 14'h0020) $display("FAIL rmb_cpu_addr: got %h want 0020", bus.mem_addr); else passes++;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_dma_read();
    test_back_to_back();
    test_contention();
    test_burst_lock();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
